// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// Latches the packet header, drives the byte bus into the output FIFOs,
// parks the one byte that arrives while the addressed FIFO is full, and
// accumulates running parity so the control FSM can check the packet.
//
// Handshake: a byte on data_in is taken only when pkt_valid is high in the
// state that consumes it; pkt_valid falling while ld_state is high marks
// the parity byte. There is no ready signal back to the source: stalls
// are signalled by the FSM through full_state/laf_state.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_addr,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] header_byte_q, header_byte_d;
    logic [DATA_WIDTH-1:0] hold_byte_q, hold_byte_d;
    logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
    logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;
    logic                  parity_done_q, parity_done_d;
    logic                  err_q, err_d;

    // Header capture: address 2'b11 is not a valid port, so it is ignored.
    always_comb begin
        header_byte_d = header_byte_q;
        if (detect_addr && pkt_valid && (data_in[1:0] != 2'b11)) begin
            header_byte_d = data_in;
        end
    end

    // Output byte bus, in priority order; a byte arriving against a full
    // FIFO is parked in hold_byte and replayed in load-after-full.
    always_comb begin
        dout_d      = dout_q;
        hold_byte_d = hold_byte_q;
        if (lfd_state) begin
            dout_d = header_byte_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte_d = data_in;
        end else if (laf_state) begin
            dout_d = hold_byte_q;
        end
    end

    // Running parity over header and payload; a payload byte is counted in
    // ld_state only, so the replay out of hold_byte is never counted twice.
    always_comb begin
        int_parity_d = int_parity_q;
        if (detect_addr) begin
            int_parity_d = '0;
        end else if (lfd_state) begin
            int_parity_d = int_parity_q ^ header_byte_q;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity_d = int_parity_q ^ data_in;
        end
    end

    // Received parity byte: the byte on which pkt_valid has dropped.
    always_comb begin
        pkt_parity_d = pkt_parity_q;
        if (detect_addr) begin
            pkt_parity_d = '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity_d = data_in;
        end
    end

    // End-of-packet flag; the FSM's check-parity state acknowledges it.
    always_comb begin
        low_pkt_valid_d = low_pkt_valid_q;
        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    // parity_done rises once the parity byte has actually left on dout,
    // either directly or replayed from hold_byte.
    always_comb begin
        parity_done_d = parity_done_q;
        if (detect_addr) begin
            parity_done_d = 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end
    end

    // Sticky parity error, compared one cycle after parity_done is seen;
    // only the next captured-header cycle clears it.
    always_comb begin
        err_d = err_q;
        if (detect_addr && pkt_valid) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (int_parity_q != pkt_parity_q);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q          <= '0;
            header_byte_q   <= '0;
            hold_byte_q     <= '0;
            int_parity_q    <= '0;
            pkt_parity_q    <= '0;
            low_pkt_valid_q <= 1'b0;
            parity_done_q   <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            dout_q          <= dout_d;
            header_byte_q   <= header_byte_d;
            hold_byte_q     <= hold_byte_d;
            int_parity_q    <= int_parity_d;
            pkt_parity_q    <= pkt_parity_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            parity_done_q   <= parity_done_d;
            err_q           <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed vector table plus hand-written corner sequences
// for router_reg. Each vector is one clock: inputs driven after the falling
// edge, outputs compared 1 time unit after the following rising edge.
module tb_router_reg;

    localparam int W = 8;

    // FSM decode codes used in the vector table
    localparam int S_IDLE = 0;
    localparam int S_DET  = 1;
    localparam int S_LFD  = 2;
    localparam int S_LD   = 3;
    localparam int S_LAF  = 4;
    localparam int S_FULL = 5;

    typedef struct {
        logic         rst_n;
        int           st;
        logic         rir;
        logic         pv;
        logic [W-1:0] din;
        logic         ff;
        logic [W-1:0] e_dout;
        logic         e_pd;
        logic         e_lpv;
        logic         e_err;
    } vec_t;

    // clock / reset block
    logic         clk = 1'b0;
    logic         rst;
    logic         pkt_valid;
    logic [W-1:0] data_in;
    logic         fifo_full;
    logic         detect_addr;
    logic         lfd_state;
    logic         ld_state;
    logic         laf_state;
    logic         full_state;
    logic         rst_int_reg;
    logic         parity_done;
    logic         low_pkt_valid;
    logic         err;
    logic [W-1:0] dout;

    always #5 clk = ~clk;

    router_reg #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_addr  (detect_addr),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
        .dout         (dout)
    );

    // scoreboard
    logic [W+2:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           vec_idx  = 0;
    vec_t         vecs[$];

    function automatic vec_t mk(input logic r, input int st, input logic rir,
                                input logic pv, input logic [W-1:0] d, input logic ff,
                                input logic [W-1:0] ed, input logic epd,
                                input logic elpv, input logic eerr);
        vec_t v;
        v.rst_n = r; v.st = st; v.rir = rir; v.pv = pv; v.din = d; v.ff = ff;
        v.e_dout = ed; v.e_pd = epd; v.e_lpv = elpv; v.e_err = eerr;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, vec_idx, act, expv);
        end
    endtask

    // driver: one clock per vector, then score against the expected queue
    task automatic apply(input vec_t v);
        logic [W+2:0] e;
        @(negedge clk);
        rst         = v.rst_n;
        pkt_valid   = v.pv;
        data_in     = v.din;
        fifo_full   = v.ff;
        detect_addr = (v.st == S_DET);
        lfd_state   = (v.st == S_LFD);
        ld_state    = (v.st == S_LD);
        laf_state   = (v.st == S_LAF);
        full_state  = (v.st == S_FULL);
        rst_int_reg = v.rir;
        exp_q.push_back({v.e_dout, v.e_pd, v.e_lpv, v.e_err});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("dout",          dout,                  e[W+2:3]);
        check_val("parity_done",   {{(W-1){1'b0}}, parity_done},   {{(W-1){1'b0}}, e[2]});
        check_val("low_pkt_valid", {{(W-1){1'b0}}, low_pkt_valid}, {{(W-1){1'b0}}, e[1]});
        check_val("err",           {{(W-1){1'b0}}, err},           {{(W-1){1'b0}}, e[0]});
        vec_idx++;
    endtask

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
        detect_addr = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
        full_state = 1'b0; rst_int_reg = 1'b0;

        //                 rst st      rir pv din    ff   dout   pd lpv err
        // reset
        vecs.push_back(mk(0, S_IDLE, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        // normal packet, addr 1, good parity
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 0, 8'h0D, 0, 8'h0D, 1, 1, 0));
        vecs.push_back(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        vecs.push_back(mk(1, S_IDLE, 0, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        // bad parity
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 0, 8'h0E, 0, 8'h0E, 1, 1, 0));
        vecs.push_back(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h0E, 1, 0, 1));
        vecs.push_back(mk(1, S_IDLE, 0, 0, 8'h00, 0, 8'h0E, 1, 0, 1));
        // full stall on payload byte 22
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h0E, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h22, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_FULL, 0, 1, 8'h22, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LAF,  0, 1, 8'h33, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 0, 8'h0D, 0, 8'h0D, 1, 1, 0));
        vecs.push_back(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        // parity byte arrives while full: header 06, payload 11 22 44, parity 71
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h06, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h06, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h44, 0, 8'h44, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 0, 8'h71, 1, 8'h44, 0, 1, 0));
        vecs.push_back(mk(1, S_FULL, 0, 0, 8'h71, 1, 8'h44, 0, 1, 0));
        vecs.push_back(mk(1, S_LAF,  0, 0, 8'h71, 0, 8'h71, 1, 1, 0));
        vecs.push_back(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h71, 1, 0, 0));
        // invalid address 3: previous header (06) is reused
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h07, 0, 8'h71, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h06, 0, 0, 0));
        // reset mid-packet, then a clean packet
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h55, 0, 8'h55, 0, 0, 0));
        vecs.push_back(mk(0, S_LD,   0, 1, 8'h66, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        vecs.push_back(mk(1, S_LD,   0, 0, 8'h0D, 0, 8'h0D, 1, 1, 0));
        vecs.push_back(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h0D, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // err stays set across idle and a header cycle without pkt_valid,
        // and clears only when a header is captured with pkt_valid
        apply(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h0D, 0, 0, 0));
        apply(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        apply(mk(1, S_LD,   0, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        apply(mk(1, S_LD,   0, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        apply(mk(1, S_LD,   0, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        apply(mk(1, S_LD,   0, 0, 8'h0F, 0, 8'h0F, 1, 1, 0));
        apply(mk(1, S_IDLE, 1, 0, 8'h00, 0, 8'h0F, 1, 0, 1));
        for (int k = 0; k < 4; k++) begin
            apply(mk(1, S_IDLE, 0, 0, 8'h00, 0, 8'h0F, 1, 0, 1));
        end
        apply(mk(1, S_DET,  0, 0, 8'h0D, 0, 8'h0F, 0, 0, 1));
        apply(mk(1, S_IDLE, 0, 0, 8'h00, 0, 8'h0F, 0, 0, 1));
        apply(mk(1, S_DET,  0, 1, 8'h0D, 0, 8'h0F, 0, 0, 0));

        // rst_int_reg wins over a low_pkt_valid set in the same cycle
        apply(mk(1, S_LFD,  0, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        apply(mk(1, S_LD,   1, 0, 8'h0D, 0, 8'h0D, 1, 0, 0));
        apply(mk(1, S_IDLE, 0, 0, 8'h00, 0, 8'h0D, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
